ddr3_avl_test_engine: RTL and testbench

DDR3_AVL_TEST_ENGINE -- requirements
Module: ddr3_avl_test_engine

---
 rtl/ddr3_test_pkg.sv | 21 ++
 rtl/ddr3_test_patgen.sv | 47 ++++
 rtl/ddr3_avl_test_engine.sv | 193 +++++++++++++++++++
 tb/tb_ddr3_avl_test_engine.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ddr3_test_pkg.sv
// ddr3_test_pkg: shared FSM states, pattern mode encodings and LFSR constants for the DDR3 Avalon test engine
package ddr3_test_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_WAIT_CAL  = 3'd1;
  localparam state_t S_WRITE     = 3'd2;
  localparam state_t S_READ_REQ  = 3'd3;
  localparam state_t S_READ_DATA = 3'd4;
  localparam state_t S_FINISH    = 3'd5;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_ADDR = 2'd0;
  localparam mode_t MODE_LFSR = 2'd1;
  localparam mode_t MODE_WALK = 2'd2;
  localparam mode_t MODE_ALT  = 2'd3;
  // x^32 + x^22 + x^2 + x + 1, Galois form with the x^32 term implied
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_ACE1;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/ddr3_test_patgen.sv
// ddr3_test_patgen: registered pattern source; clear loads beat 0, advance steps to the next beat index
module ddr3_test_patgen
  import ddr3_test_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  mode_t             i_mode,
  input  logic              i_clr,
  input  logic              i_adv,
  output logic [DATA_W-1:0] o_data
);
  logic [31:0]       r_n, r_lfsr, w_lfsr_nxt;
  logic [DATA_W-1:0] r_walk, r_data, w_walk_nxt;
  function automatic logic [DATA_W-1:0] f_pat(input mode_t m, input logic [31:0] n,
                                               input logic [31:0] lfsr, input logic [DATA_W-1:0] walk);
    logic [DATA_W-1:0] rep;
    for (int i = 0; i < DATA_W; i++) rep[i] = lfsr[i[4:0]];
    return m == MODE_ADDR ? DATA_W'(n) :
           m == MODE_LFSR ? rep :
           m == MODE_WALK ? walk : {DATA_W{~n[0]}};
  endfunction
  always_comb begin
    w_lfsr_nxt = lfsr_next(r_lfsr);
    w_walk_nxt = {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n    <= '0;
      r_lfsr <= '0;
      r_walk <= '0;
      r_data <= '0;
    end else if (i_clr) begin
      r_n    <= '0;
      r_lfsr <= LFSR_SEED;
      r_walk <= DATA_W'(1);
      r_data <= f_pat(i_mode, 32'd0, LFSR_SEED, DATA_W'(1));
    end else if (i_adv) begin
      r_n    <= r_n + 32'd1;
      r_lfsr <= w_lfsr_nxt;
      r_walk <= w_walk_nxt;
      r_data <= f_pat(i_mode, r_n + 32'd1, w_lfsr_nxt, w_walk_nxt);
    end
  end
  assign o_data = r_data;
endmodule

// File: rtl/ddr3_avl_test_engine.sv
// ddr3_avl_test_engine: write-all/read-back Avalon burst tester for a DDR3 EMIF.
// Define DDR3_TEST_ERR_INJECT_EN to add inject_err, which flips bit 0 of the first write beat.
module ddr3_avl_test_engine
  import ddr3_test_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 25,
  parameter int BURST_LEN = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                local_init_done,
  input  logic                local_cal_success,
  input  logic                local_cal_fail,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         num_bursts,
`ifdef DDR3_TEST_ERR_INJECT_EN
  input  logic                inject_err,
`endif
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [6:0]          avm_burstcount,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                cal_err,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);
  localparam logic [6:0]        BL7  = 7'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BL_A = ADDR_W'(BURST_LEN);
  state_t              r_state;
  mode_t               r_mode;
  logic [ADDR_W-1:0]   r_base, r_addr, r_first;
  logic [15:0]         r_num, r_burst, r_err, w_err_nxt;
  logic [6:0]          r_beat, r_bc;
  logic [DATA_W/8-1:0] r_be;
  logic                r_write, r_read, r_busy, r_done, r_pass, r_fail, r_cal_err;
  logic                w_cal_ok, w_abort, w_clr, w_wacc, w_racc, w_rvld, w_mis, w_last_beat, w_last_burst;
  logic [DATA_W-1:0]   w_wr_pat, w_exp;
  always_comb begin
    w_cal_ok     = local_init_done & local_cal_success;
    w_abort      = (r_state == S_WRITE || r_state == S_READ_REQ || r_state == S_READ_DATA) && !w_cal_ok;
    w_clr        = r_state == S_WAIT_CAL;
    w_wacc       = r_state == S_WRITE && r_write && !avm_waitrequest;
    w_racc       = r_state == S_READ_REQ && r_read && !avm_waitrequest;
    w_rvld       = r_state == S_READ_DATA && avm_readdatavalid;
    w_mis        = w_rvld && avm_readdata != w_exp;
    w_err_nxt    = r_err + {15'd0, w_mis && r_err != 16'hFFFF};
    w_last_beat  = r_beat == BL7 - 7'd1;
    w_last_burst = r_burst == r_num - 16'd1;
  end
  ddr3_test_patgen #(.DATA_W(DATA_W)) u_wr_gen (
    .clk(clk_clk), .rst(reset_reset), .i_mode(r_mode), .i_clr(w_clr), .i_adv(w_wacc), .o_data(w_wr_pat)
  );
  ddr3_test_patgen #(.DATA_W(DATA_W)) u_chk_gen (
    .clk(clk_clk), .rst(reset_reset), .i_mode(r_mode), .i_clr(w_clr), .i_adv(w_rvld), .o_data(w_exp)
  );
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state   <= S_IDLE;
      r_mode    <= MODE_ADDR;
      r_base    <= '0;
      r_addr    <= '0;
      r_first   <= '0;
      r_num     <= '0;
      r_burst   <= '0;
      r_err     <= '0;
      r_beat    <= '0;
      r_bc      <= '0;
      r_be      <= '0;
      r_write   <= 1'b0;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_cal_err <= 1'b0;
    end else if (w_abort) begin
      r_state   <= S_FINISH;
      r_write   <= 1'b0;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b1;
      r_pass    <= 1'b0;
      r_fail    <= 1'b1;
      r_cal_err <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_FINISH: if (start) begin
          r_state   <= S_WAIT_CAL;
          r_mode    <= mode;
          r_base    <= base_addr;
          r_num     <= num_bursts;
          r_err     <= '0;
          r_first   <= '0;
          r_done    <= 1'b0;
          r_pass    <= 1'b0;
          r_fail    <= 1'b0;
          r_cal_err <= 1'b0;
          r_busy    <= 1'b1;
          r_be      <= '1;
          r_bc      <= BL7;
        end
        S_WAIT_CAL: if (w_cal_ok) begin
          r_addr  <= r_base;
          r_beat  <= '0;
          r_burst <= '0;
          r_state <= r_num == 16'd0 ? S_FINISH : S_WRITE;
          r_write <= r_num != 16'd0;
          r_busy  <= r_num != 16'd0;
          r_done  <= r_num == 16'd0;
          r_pass  <= r_num == 16'd0;
        end else if (local_cal_fail) begin
          r_state   <= S_FINISH;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_fail    <= 1'b1;
          r_cal_err <= 1'b1;
        end
        S_WRITE: if (w_wacc) begin
          r_beat <= w_last_beat ? 7'd0 : r_beat + 7'd1;
          if (w_last_beat && w_last_burst) begin
            r_state <= S_READ_REQ;
            r_write <= 1'b0;
            r_read  <= 1'b1;
            r_addr  <= r_base;
            r_burst <= '0;
          end else if (w_last_beat) begin
            r_addr  <= r_addr + BL_A;
            r_burst <= r_burst + 16'd1;
          end
        end
        S_READ_REQ: if (w_racc) begin
          r_read  <= 1'b0;
          r_state <= S_READ_DATA;
        end
        S_READ_DATA: begin
          r_err <= w_err_nxt;
          if (w_mis && r_err == 16'd0) r_first <= r_addr + ADDR_W'(r_beat);
          if (w_rvld) begin
            r_beat <= w_last_beat ? 7'd0 : r_beat + 7'd1;
            if (w_last_beat && w_last_burst) begin
              r_state <= S_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_err_nxt == 16'd0;
              r_fail  <= w_err_nxt != 16'd0;
            end else if (w_last_beat) begin
              r_state <= S_READ_REQ;
              r_read  <= 1'b1;
              r_addr  <= r_addr + BL_A;
              r_burst <= r_burst + 16'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef DDR3_TEST_ERR_INJECT_EN
  logic r_inj;
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) r_inj <= 1'b0;
    else if ((r_state == S_IDLE || r_state == S_FINISH) && start) r_inj <= inject_err;
    else if (w_wacc) r_inj <= 1'b0;
  end
  assign avm_writedata = w_wr_pat ^ DATA_W'(r_inj);
`else
  assign avm_writedata = w_wr_pat;
`endif
  assign avm_address    = r_addr;
  assign avm_read       = r_read;
  assign avm_write      = r_write;
  assign avm_byteenable = r_be;
  assign avm_burstcount = r_bc;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail           = r_fail;
  assign cal_err        = r_cal_err;
  assign err_count      = r_err;
  assign first_err_addr = r_first;
endmodule

// File: tb/tb_ddr3_avl_test_engine.sv
// tb_ddr3_avl_test_engine: Avalon memory model plus behavioural pattern model checking the DDR3 test engine
module tb_ddr3_avl_test_engine;
  localparam int DW = 64, AW = 25, BL = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic init_done = 1'b1, cal_ok = 1'b1, cal_fail = 1'b0, start = 1'b0;
  logic [1:0] mode = '0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0] num_bursts = '0;
  logic [AW-1:0] avm_address;
  logic avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic [6:0] avm_burstcount;
  logic avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic busy, done, pass, fail, cal_err;
  logic [15:0] err_count;
  logic [AW-1:0] first_err_addr;
  int total = 0, bad = 0;
  int t_mode = 0, t_nb = 0, wcnt = 0, rcnt = 0, rbursts = 0, corrupt_addr = -1, wait_pct = 0;
  logic [AW-1:0] t_base = '0, b1_addr = '1;
  logic [DW-1:0] mem [int];
  logic [AW-1:0] rq [$];
  logic h_valid = 1'b0;
  logic [AW-1:0] h_addr, drv_a;
  logic [DW-1:0] h_data, drv_d;

  ddr3_avl_test_engine #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL)) dut (
    .clk_clk(clk), .reset_reset(rst), .local_init_done(init_done), .local_cal_success(cal_ok),
    .local_cal_fail(cal_fail), .start(start), .mode(mode), .base_addr(base_addr), .num_bursts(num_bursts),
`ifdef DDR3_TEST_ERR_INJECT_EN
    .inject_err(1'b0),
`endif
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .cal_err(cal_err), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected word n of a test, straight from the pattern definitions
  function automatic logic [DW-1:0] f_exp(input int m, input int n);
    logic [31:0] s = 32'hACE1_ACE1;
    if (m == 0) return DW'(unsigned'(n));
    if (m == 1) begin
      for (int i = 0; i < n; i++) s = s[31] ? ((s << 1) ^ 32'h0040_0007) : (s << 1);
      return {s, s};
    end
    if (m == 2) return DW'(1) << (n % DW);
    return n[0] ? '0 : '1;
  endfunction

  // Memory slave: random waitrequest, in-order read returns one cycle after acceptance
  always @(posedge clk) begin
    #1;
    avm_waitrequest = wait_pct > 0 && $urandom_range(99) < wait_pct;
    if (rq.size() > 0) begin
      drv_a = rq.pop_front();
      drv_d = mem.exists(int'(drv_a)) ? mem[int'(drv_a)] : '0;
      if (int'(drv_a) == corrupt_addr) drv_d[5] = ~drv_d[5];
      avm_readdatavalid = 1'b1;
      avm_readdata = drv_d;
      rcnt++;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
    end
  end

  always @(negedge clk) begin
    if (rst) h_valid = 1'b0;
    else begin
      if (h_valid) begin
        chk("hold_write", avm_write, 1);
        chk("hold_addr", avm_address, h_addr);
        chk("hold_data", avm_writedata, h_data);
      end
      if (avm_read || avm_write) chk("busy_on_bus", busy, 1);
      if (avm_write && !avm_waitrequest) begin
        chk("wr_addr", avm_address, AW'(t_base + (wcnt / BL) * BL));
        chk("wr_data", avm_writedata, f_exp(t_mode, wcnt));
        chk("wr_bc", avm_burstcount, BL);
        chk("wr_be", avm_byteenable, 8'hFF);
        chk("wr_before_rd", rbursts, 0);
        if (wcnt == BL) b1_addr = avm_address;
        mem[int'(AW'(avm_address + AW'(wcnt % BL)))] = avm_writedata;
        wcnt++;
      end
      if (avm_read && !avm_waitrequest) begin
        chk("rd_addr", avm_address, AW'(t_base + rbursts * BL));
        chk("rd_after_wr", wcnt, t_nb * BL);
        for (int i = 0; i < BL; i++) rq.push_back(AW'(avm_address + AW'(i)));
        rbursts++;
      end
      h_valid = avm_write && avm_waitrequest;
      h_addr = avm_address;
      h_data = avm_writedata;
    end
  end

  task automatic kick(input int m, input int b, input int nb);
    t_mode = m; t_base = AW'(b); t_nb = nb;
    wcnt = 0; rcnt = 0; rbursts = 0; b1_addr = '1;
    rq.delete(); mem.delete();
    @(posedge clk) #1;
    mode = 2'(m); base_addr = AW'(b); num_bursts = 16'(nb); start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  task automatic run(input string nm, input int m, input int b, input int nb, input bit ep,
                     input bit ec, input int ee, input int ef, input int ew, input int er);
    kick(m, b, nb);
    for (int i = 0; i < 5000 && !done; i++) @(negedge clk);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_pass"}, pass, ep);
    chk({nm, "_fail"}, fail, !ep);
    chk({nm, "_cal_err"}, cal_err, ec);
    chk({nm, "_err_count"}, err_count, ee);
    chk({nm, "_first_err"}, first_err_addr, ef);
    chk({nm, "_writes"}, wcnt, ew);
    chk({nm, "_reads"}, rcnt, er);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    chk("pin_addr", f_exp(0, 19), 64'h13);
    chk("pin_lfsr0", f_exp(1, 0), 64'hACE1ACE1_ACE1ACE1);
    chk("pin_lfsr1", f_exp(1, 1), 64'h598359C5_598359C5);
    chk("pin_walk", f_exp(2, 70), 64'h40);
    chk("pin_alt_odd", f_exp(3, 3), 64'h0);
    chk("pin_alt_even", f_exp(3, 4), 64'hFFFFFFFF_FFFFFFFF);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_cal_err", cal_err, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_addr, 0);
    chk("rst_bus", {avm_read, avm_write, avm_address, avm_burstcount, avm_byteenable}, 0);
    chk("rst_wdata", avm_writedata, 0);
    run("addr", 0, 0, 4, 1, 0, 0, 0, 32, 32);
    wait_pct = 50;
    run("lfsr", 1, 'h100, 16, 1, 0, 0, 0, 128, 128);
    wait_pct = 0;
    corrupt_addr = 'h13;
    run("corrupt", 2, 0, 4, 0, 0, 1, 'h13, 32, 32);
    corrupt_addr = -1;
    init_done = 1'b0; cal_ok = 1'b0; cal_fail = 1'b1;
    run("cal_fail", 0, 0, 4, 0, 1, 0, 0, 0, 0);
    init_done = 1'b1; cal_ok = 1'b1; cal_fail = 1'b0;
    run("wrap", 3, (1 << AW) - 8, 2, 1, 0, 0, 0, 16, 16);
    chk("wrap_b1_addr", b1_addr, 0);
    run("zero", 1, 'h40, 0, 1, 0, 0, 0, 0, 0);
    // calibration lost during read-back
    kick(3, 0, 4);
    for (int i = 0; i < 1000 && rcnt < 3; i++) @(negedge clk);
    chk("abort_reached_reads", rcnt >= 3, 1);
    @(posedge clk) #1 cal_ok = 1'b0;
    @(posedge clk) #1;
    chk("abort_rw", {avm_read, avm_write}, 0);
    chk("abort_cal_err", cal_err, 1);
    chk("abort_done", done, 1);
    chk("abort_fail", {fail, pass}, 2'b10);
    chk("abort_busy", busy, 0);
    cal_ok = 1'b1;
    // reset in the middle of the write phase
    kick(0, 0, 4);
    for (int i = 0; i < 1000 && wcnt < 5; i++) @(negedge clk);
    chk("rst_mid_reached", wcnt >= 5, 1);
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_write", avm_write, 0);
    chk("rst_mid_done", done, 0);
    rst = 1'b0;
    run("after_rst", 0, 0, 4, 1, 0, 0, 0, 32, 32);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
